// File: rtl/music_pkg.sv
// Shared definitions for the music playback address sequencer.
//   state_e      : sequencer state (EMPTY, PLAY, PAUSE, DONE)
//   CLK_HZ       : system clock frequency
//   SAMPLE_RATE  : audio sample rate
//   SKIP_SECONDS : seek distance in seconds
//   SKIP_DEFAULT : samples moved per seek press
//   DIV_DEFAULT  : clock cycles per audio sample
package music_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int CLK_HZ       = 50_000_000;
    localparam int SAMPLE_RATE  = 8_000;
    localparam int SKIP_SECONDS = 10;
    localparam int SKIP_DEFAULT = SAMPLE_RATE * SKIP_SECONDS;
    localparam int DIV_DEFAULT  = CLK_HZ / SAMPLE_RATE;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for an already synchronised button.
//   clk, reset : clock and asynchronous active-high reset
//   btn        : button level
//   rise       : high in the cycle where btn is high and was low last cycle
// RST_VAL sets the history register on reset; resetting it to 1 means a
// button that is already held when reset releases does not count as a press.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_d;
    logic btn_q;

    always_comb begin
        btn_d = btn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= RST_VAL;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/music_addr_seq.sv
// Playback address sequencer: walks endereco through the loaded window
// [track_start, track_end] at one sample every DIV clocks, with play/pause,
// +/-SKIP seeking clamped to the window, optional looping and an
// end-of-track pulse.
//   clk, reset             : clock, asynchronous active-high reset
//   load                   : latch track_start/track_end (ignored if start > end)
//   track_start, track_end : track window
//   count                  : 1 = play, 0 = pause
//   loop_en                : wrap to track_start after track_end
//   passa_10s, volta_10s   : seek forward / back buttons (synchronised)
//   endereco               : current sample address
//   sample_tick            : one-cycle pulse when a sample advance is applied
//   fim                    : one-cycle pulse when track_end is passed
//   playing                : high in PLAY
//   state_dbg              : current sequencer state, for observation
// Same-cycle priority is load > seek > tick; both seek buttons rising
// together cancel out.
module music_addr_seq
    import music_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int SKIP   = SKIP_DEFAULT,
    parameter int DIV    = DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] track_start,
    input  logic [ADDR_W-1:0] track_end,
    input  logic              count,
    input  logic              loop_en,
    input  logic              passa_10s,
    input  logic              volta_10s,
    output logic [ADDR_W-1:0] endereco,
    output logic              sample_tick,
    output logic              fim,
    output logic              playing,
    output state_e            state_dbg
);

    localparam int                DIV_W    = $clog2(DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [ADDR_W:0]   SKIP_X   = (ADDR_W + 1)'(SKIP);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic                fim_q, fim_d;
    logic                playing_q, playing_d;

    logic                fwd_rise, back_rise;
    logic                seek_fwd, seek_back;
    logic                load_ok, div_wrap;
    logic [ADDR_W:0]     fwd_sum, back_gap;
    logic [ADDR_W-1:0]   fwd_addr, back_addr;
    state_e              run_state;

    rise_detect #(.RST_VAL(1'b1)) u_fwd_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (passa_10s),
        .rise  (fwd_rise)
    );

    rise_detect #(.RST_VAL(1'b1)) u_back_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (volta_10s),
        .rise  (back_rise)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_d   = start_q;
        end_d     = end_q;
        div_d     = div_q;
        tick_d    = 1'b0;
        fim_d     = 1'b0;

        seek_fwd  = fwd_rise & ~back_rise;
        seek_back = back_rise & ~fwd_rise;
        load_ok   = load && (track_start <= track_end);
        div_wrap  = (div_q == DIV_LAST);
        run_state = count ? ST_PLAY : ST_PAUSE;

        // One extra bit so addr + SKIP can never wrap before the clamp.
        fwd_sum   = {1'b0, addr_q} + SKIP_X;
        fwd_addr  = (fwd_sum > {1'b0, end_q}) ? end_q : fwd_sum[ADDR_W-1:0];
        back_gap  = {1'b0, addr_q - start_q};
        back_addr = (back_gap < SKIP_X) ? start_q : addr_q - SKIP_X[ADDR_W-1:0];

        if (load_ok) begin
            start_d = track_start;
            end_d   = track_end;
            addr_d  = track_start;
            div_d   = '0;
            state_d = run_state;
        end else begin
            case (state_q)
                ST_PLAY, ST_PAUSE: begin
                    state_d = run_state;
                    // The divider phase survives a pause; it only runs in PLAY.
                    if (state_q == ST_PLAY) begin
                        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                    end
                    if (seek_fwd) begin
                        addr_d = fwd_addr;
                    end else if (seek_back) begin
                        addr_d = back_addr;
                    end else if (state_q == ST_PLAY && div_wrap) begin
                        tick_d = 1'b1;
                        if (addr_q < end_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            fim_d = 1'b1;
                            if (loop_en) begin
                                addr_d = start_q;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (seek_back) begin
                        addr_d  = back_addr;
                        state_d = run_state;
                    end
                end
                default: begin
                end
            endcase
        end

        playing_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            addr_q    <= '0;
            start_q   <= '0;
            end_q     <= '0;
            div_q     <= '0;
            tick_q    <= 1'b0;
            fim_q     <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            start_q   <= start_d;
            end_q     <= end_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            fim_q     <= fim_d;
            playing_q <= playing_d;
        end
    end

    assign endereco    = addr_q;
    assign sample_tick = tick_q;
    assign fim         = fim_q;
    assign playing     = playing_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_music_addr_seq.sv
// Testbench for music_addr_seq with ADDR_W=8, DIV=4, SKIP=10.
// Expected addresses for each sample_tick are queued when the stimulus that
// causes them is driven; a negedge monitor pops and compares them.
module tb_music_addr_seq;
    import music_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DIV    = 4;
    localparam int SKIP   = 10;

    logic              clk;
    logic              reset;
    logic              load;
    logic [ADDR_W-1:0] track_start;
    logic [ADDR_W-1:0] track_end;
    logic              count;
    logic              loop_en;
    logic              passa_10s;
    logic              volta_10s;
    logic [ADDR_W-1:0] endereco;
    logic              sample_tick;
    logic              fim;
    logic              playing;
    state_e            state_dbg;

    int                n_checks;
    int                n_fail;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] mon_exp;

    music_addr_seq #(
        .ADDR_W (ADDR_W),
        .SKIP   (SKIP),
        .DIV    (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .track_start (track_start),
        .track_end   (track_end),
        .count       (count),
        .loop_en     (loop_en),
        .passa_10s   (passa_10s),
        .volta_10s   (volta_10s),
        .endereco    (endereco),
        .sample_tick (sample_tick),
        .fim         (fim),
        .playing     (playing),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && sample_tick) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tick_unexpected: sample_tick=1 endereco=%0d, required no tick", endereco);
            end else begin
                mon_exp = exp_q.pop_front();
                if (endereco !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tick_addr: endereco=%0d, required %0d", endereco, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int s, input int e, input logic cnt, input logic lp);
        track_start = ADDR_W'(s);
        track_end   = ADDR_W'(e);
        count       = cnt;
        loop_en     = lp;
        load        = 1'b1;
        step();
        load        = 1'b0;
    endtask

    task automatic press(input logic fwd, input logic back);
        passa_10s = fwd;
        volta_10s = back;
        step();
    endtask

    task automatic release_btn();
        passa_10s = 1'b0;
        volta_10s = 1'b0;
        step();
    endtask

    task automatic wait_tick(input int max_cycles, output int waited, output bit got);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < max_cycles) begin
            step();
            waited++;
            if (sample_tick) got = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; load = 1'b0; track_start = '0; track_end = '0;
        count = 1'b0; loop_en = 1'b0; passa_10s = 1'b0; volta_10s = 1'b0;
        step(3);
        n_checks++;
        if (endereco !== 0 || playing !== 1'b0 || sample_tick !== 1'b0 || fim !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: endereco=%0d playing=%b tick=%b fim=%b, required 0 0 0 0",
                     endereco, playing, sample_tick, fim);
        end
        n_checks++;
        if (state_dbg !== ST_EMPTY) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d, required %0d", state_dbg, ST_EMPTY);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_play();
        int ticks;
        do_load(20, 60, 1'b1, 1'b0);
        n_checks++;
        if (endereco !== 8'd20 || playing !== 1'b1 || state_dbg !== ST_PLAY) begin
            n_fail++;
            $display("FAIL load_play: endereco=%0d playing=%b state=%0d, required 20 1 %0d",
                     endereco, playing, state_dbg, ST_PLAY);
        end
        exp_q.push_back(8'd21);
        exp_q.push_back(8'd22);
        exp_q.push_back(8'd23);
        ticks = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (sample_tick) begin
                ticks++;
                n_checks++;
                if (k % DIV != 0) begin
                    n_fail++;
                    $display("FAIL tick_spacing: tick at cycle %0d after load, required multiple of %0d", k, DIV);
                end
            end
        end
        n_checks++;
        if (ticks != 3 || endereco !== 8'd23) begin
            n_fail++;
            $display("FAIL play_run: ticks=%0d endereco=%0d, required 3 23", ticks, endereco);
        end
        count = 1'b0;
    endtask

    task automatic test_seek();
        // op: 1 = passa, 2 = volta, 3 = both together
        int ops  [13] = '{1, 2, 1, 3, 1, 1, 1, 1, 2, 2, 2, 2, 2};
        int exps [13] = '{25, 15, 25, 25, 35, 45, 55, 60, 50, 40, 30, 20, 15};

        do_load(20, 60, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        n_checks++;
        if (endereco !== 8'd30) begin
            n_fail++;
            $display("FAIL seek_fwd_20: endereco=%0d, required 30", endereco);
        end
        release_btn();
        press(1'b1, 1'b0);
        n_checks++;
        if (endereco !== 8'd40) begin
            n_fail++;
            $display("FAIL seek_fwd_30: endereco=%0d, required 40", endereco);
        end
        release_btn();

        do_load(15, 60, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            press(ops[i][0], ops[i][1]);
            n_checks++;
            if (endereco !== ADDR_W'(exps[i]) || fim !== 1'b0 || state_dbg !== ST_PAUSE) begin
                n_fail++;
                $display("FAIL seek_step%0d: endereco=%0d fim=%b state=%0d, required %0d 0 %0d",
                         i, endereco, fim, state_dbg, exps[i], ST_PAUSE);
            end
            release_btn();
        end

        // A long hold is one press.
        press(1'b1, 1'b0);
        n_checks++;
        if (endereco !== 8'd25) begin
            n_fail++;
            $display("FAIL hold_first: endereco=%0d, required 25", endereco);
        end
        step(49);
        n_checks++;
        if (endereco !== 8'd25) begin
            n_fail++;
            $display("FAIL hold_50: endereco=%0d, required 25", endereco);
        end
        release_btn();
    endtask

    task automatic test_pause();
        int waited;
        bit got;
        do_load(20, 60, 1'b1, 1'b0);
        exp_q.push_back(8'd21);
        wait_tick(10, waited, got);
        n_checks++;
        if (!got || waited != DIV) begin
            n_fail++;
            $display("FAIL pause_first_tick: got=%0d waited=%0d, required 1 %0d", got, waited, DIV);
        end
        step();
        count = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (endereco !== 8'd21) begin
                n_fail++;
                $display("FAIL pause_frozen: endereco=%0d, required 21", endereco);
            end
        end
        // Paused with the divider at 2: one cycle to re-enter PLAY, then
        // 2->3 and the wrap, so the tick shows three cycles after count=1.
        exp_q.push_back(8'd22);
        count = 1'b1;
        wait_tick(10, waited, got);
        n_checks++;
        if (!got || waited != 3) begin
            n_fail++;
            $display("FAIL resume_phase: got=%0d waited=%0d, required 1 3", got, waited);
        end
        count = 1'b0;
    endtask

    task automatic test_end_noloop();
        int waited;
        int fims;
        bit got;
        do_load(20, 60, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0);
            release_btn();
        end
        exp_q.push_back(8'd60);
        count = 1'b1;
        wait_tick(12, waited, got);
        n_checks++;
        if (!got || fim !== 1'b1 || playing !== 1'b0 || state_dbg !== ST_DONE) begin
            n_fail++;
            $display("FAIL end_noloop: got=%0d fim=%b playing=%b state=%0d, required 1 1 0 %0d",
                     got, fim, playing, state_dbg, ST_DONE);
        end
        fims = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (fim) fims++;
        end
        n_checks++;
        if (fims != 0 || endereco !== 8'd60) begin
            n_fail++;
            $display("FAIL done_hold: fim_pulses=%0d endereco=%0d, required 0 60", fims, endereco);
        end
        press(1'b0, 1'b1);
        n_checks++;
        if (endereco !== 8'd50 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL done_volta: endereco=%0d playing=%b, required 50 1", endereco, playing);
        end
        release_btn();
        exp_q.push_back(8'd51);
        wait_tick(8, waited, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_resume_tick: got=%0d, required 1", got);
        end
        count = 1'b0;
    endtask

    task automatic test_loop();
        int waited;
        bit got;
        do_load(20, 60, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0);
            release_btn();
        end
        exp_q.push_back(8'd20);
        count = 1'b1;
        wait_tick(12, waited, got);
        n_checks++;
        if (!got || fim !== 1'b1 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_wrap: got=%0d fim=%b playing=%b, required 1 1 1", got, fim, playing);
        end
        count = 1'b0;
        step();
        n_checks++;
        if (fim !== 1'b0 || endereco !== 8'd20) begin
            n_fail++;
            $display("FAIL loop_after: fim=%b endereco=%0d, required 0 20", fim, endereco);
        end
        // Reversed window must be ignored: address, state and old window kept.
        do_load(70, 30, 1'b0, 1'b1);
        n_checks++;
        if (endereco !== 8'd20 || state_dbg !== ST_PAUSE) begin
            n_fail++;
            $display("FAIL bad_load: endereco=%0d state=%0d, required 20 %0d", endereco, state_dbg, ST_PAUSE);
        end
        press(1'b1, 1'b0);
        release_btn();
        press(1'b1, 1'b0);
        n_checks++;
        if (endereco !== 8'd40) begin
            n_fail++;
            $display("FAIL bad_load_window: endereco=%0d, required 40", endereco);
        end
        release_btn();
    endtask

    task automatic test_async_reset();
        do_load(20, 60, 1'b1, 1'b0);
        exp_q.push_back(8'd21);
        step(6);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (endereco !== 0 || playing !== 1'b0 || state_dbg !== ST_EMPTY) begin
            n_fail++;
            $display("FAIL async_reset: endereco=%0d playing=%b state=%0d, required 0 0 %0d",
                     endereco, playing, state_dbg, ST_EMPTY);
        end
        count = 1'b0;
        step(2);
        reset = 1'b0;
        step();
        press(1'b0, 1'b1);
        release_btn();
        press(1'b1, 1'b0);
        n_checks++;
        if (endereco !== 0 || state_dbg !== ST_EMPTY || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_seek: endereco=%0d state=%0d playing=%b, required 0 %0d 0",
                     endereco, state_dbg, playing, ST_EMPTY);
        end
        release_btn();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_play();
        test_seek();
        test_pause();
        test_end_noloop();
        test_loop();
        test_async_reset();
        step(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected ticks outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
